// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial packed-BCD datapath:
//   BCD_W     width of one BCD digit
//   BCD_MAX   largest legal digit value
//   BCD_BASE  radix used to fold a negative digit difference back into range
//   state_e   control states of the serial subtractor
//   digit_gt_max() flags a nibble that is not a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_e;

  // A nibble above 9 cannot be a BCD digit.
  function automatic logic digit_gt_max(input logic [BCD_W-1:0] d);
    return (d > BCD_W'(BCD_MAX));
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtractor: diff = a - b - borrow_in, folded
// into 0..9 with a borrow out when the raw difference goes negative.
// Ports:
//   a_i[3:0]    minuend digit (0..9)
//   b_i[3:0]    subtrahend digit (0..9)
//   borrow_i    borrow from the next-lower digit
//   diff_o[3:0] result digit (0..9)
//   borrow_o    borrow into the next-higher digit
// -----------------------------------------------------------------------------
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             borrow_i,
  output logic [BCD_W-1:0] diff_o,
  output logic             borrow_o
);

  // 5-bit two's-complement difference; range is -10..9 for legal digits.
  logic [BCD_W:0] t_s;

  // Raw difference, then add the base back when it went negative.
  always_comb begin
    t_s = {1'b0, a_i} - {1'b0, b_i} - {{BCD_W{1'b0}}, borrow_i};
    if (t_s[BCD_W]) begin
      // Adding 10 modulo 16 on the low nibble gives the wrapped digit.
      diff_o   = t_s[BCD_W-1:0] + BCD_W'(BCD_BASE);
      borrow_o = 1'b1;
    end else begin
      diff_o   = t_s[BCD_W-1:0];
      borrow_o = 1'b0;
    end
  end

endmodule : bcd_digit_sub

// File: rtl/bcd_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bcd_serial_subtractor
// Serial packed-BCD subtractor computing |A - B| one digit per clock, LSD
// first. When the first pass ends with a borrow the raw result is the ten's
// complement of the magnitude, so a second pass computes 0 - raw to recover
// it and the sign is reported separately.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    start request, only looked at in IDLE
//   a_i        minuend, packed BCD, digit 0 in [3:0]
//   b_i        subtrahend, packed BCD
//   busy_o     operation in progress (SUB, NEG or DONE)
//   done_o     one-cycle pulse, results valid
//   diff_o     magnitude of A - B, packed BCD
//   neg_o      A < B
//   invalid_o  an operand digit was above 9
// -----------------------------------------------------------------------------
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [BCD_W*DIGITS-1:0]   a_i,
  input  logic [BCD_W*DIGITS-1:0]   b_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [BCD_W*DIGITS-1:0]   diff_o,
  output logic                      neg_o,
  output logic                      invalid_o
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             neg_q, neg_d;
  logic             inv_q, inv_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             in_invalid_s;
  logic             last_s;
  logic [BCD_W-1:0] sub_a_s, sub_b_s, sub_diff_s;
  logic             sub_bin_s, sub_bout_s;
  logic [W-1:0]     res_shift_s;

  // Flag any non-BCD nibble on the operand inputs at acceptance time.
  always_comb begin
    in_invalid_s = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      in_invalid_s = in_invalid_s
                   | digit_gt_max(a_i[k*BCD_W +: BCD_W])
                   | digit_gt_max(b_i[k*BCD_W +: BCD_W]);
    end
  end

  // Select the digit-subtractor operands: A/B in SUB, 0 - raw result in NEG.
  always_comb begin
    sub_a_s   = {BCD_W{1'b0}};
    sub_b_s   = {BCD_W{1'b0}};
    sub_bin_s = borrow_q;
    if (state_q == NEG) begin
      sub_a_s = {BCD_W{1'b0}};
      sub_b_s = res_q[BCD_W-1:0];
    end else begin
      sub_a_s = a_q[BCD_W-1:0];
      sub_b_s = b_q[BCD_W-1:0];
    end
  end

  bcd_digit_sub u_digit_sub (
    .a_i      (sub_a_s),
    .b_i      (sub_b_s),
    .borrow_i (sub_bin_s),
    .diff_o   (sub_diff_s),
    .borrow_o (sub_bout_s)
  );

  // The result register rotates: the digit just consumed from the bottom is
  // replaced by the new digit entering at the top, so after DIGITS steps every
  // digit is back in its own position.
  assign res_shift_s = (res_q >> BCD_W) | (W'(sub_diff_s) << (W - BCD_W));
  assign last_s      = (idx_q == LAST_IDX);

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    inv_d    = inv_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          idx_d    = {IDX_W{1'b0}};
          borrow_d = 1'b0;
          neg_d    = 1'b0;
          inv_d    = 1'b0;
          if (in_invalid_s) begin
            state_d = DONE;
            inv_d   = 1'b1;
            diff_d  = {W{1'b0}};
          end else begin
            state_d = SUB;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SUB: begin
        a_d      = a_q >> BCD_W;
        b_d      = b_q >> BCD_W;
        res_d    = res_shift_s;
        borrow_d = sub_bout_s;
        if (last_s) begin
          idx_d = {IDX_W{1'b0}};
          if (sub_bout_s) begin
            // Raw result is the ten's complement; restart the borrow chain.
            state_d  = NEG;
            borrow_d = 1'b0;
          end else begin
            state_d  = DONE;
            diff_d   = res_shift_s;
            neg_d    = 1'b0;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      NEG: begin
        res_d    = res_shift_s;
        borrow_d = sub_bout_s;
        if (last_s) begin
          idx_d    = {IDX_W{1'b0}};
          borrow_d = 1'b0;
          state_d  = DONE;
          diff_d   = res_shift_s;
          neg_d    = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they line up with it.
  always_comb begin
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, counter, operand/result and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= {IDX_W{1'b0}};
      borrow_q <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      res_q    <= {W{1'b0}};
      diff_q   <= {W{1'b0}};
      neg_q    <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign diff_o    = diff_q;
  assign neg_o     = neg_q;
  assign invalid_o = inv_q;

endmodule : bcd_serial_subtractor
